// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: demand-actuated round-robin controller for NUM_PHASES conflicting phases.
// Define TSEQ_MAX_GREEN_EN to let live own-phase demand extend green up to MAX_GREEN.
module traffic_phase_sequencer #(
  parameter int NUM_PHASES   = 4,
  parameter int CNT_W        = 8,
  parameter int MIN_GREEN    = 5,
  parameter int MAX_GREEN    = 20,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 1,
  localparam int PH_W        = $clog2(NUM_PHASES)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_PHASES-1:0]   demand,
  input  logic                    flash,
  output logic [2*NUM_PHASES-1:0] light,
  output logic [PH_W-1:0]         phase_id,
  output logic                    green_start
);

  // state   | meaning
  // ALL_RED | clearance interval; rests here at count 0 while nothing is demanded
  // GREEN   | phase_id has right of way; may rest here while no other demand exists
  // YELLOW  | phase_id clearing before all-red
  // FLASH   | maintenance flash, all lamps flashing yellow, timers frozen

  if (NUM_PHASES < 2 || NUM_PHASES > 16 || MIN_GREEN < 1 || MAX_GREEN < MIN_GREEN ||
      YELLOW_TIME < 1 || ALL_RED_TIME < 1 || MAX_GREEN >= (1 << CNT_W) ||
      YELLOW_TIME >= (1 << CNT_W) || ALL_RED_TIME >= (1 << CNT_W)) begin : g_bad_params
    $error("traffic_phase_sequencer: illegal parameter set");
  end

  typedef enum logic [1:0] {S_ALL_RED, S_GREEN, S_YELLOW, S_FLASH} state_t;

  localparam logic [CNT_W-1:0] YELLOW_LOAD  = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] ALL_RED_LOAD = CNT_W'(ALL_RED_TIME - 1);
`ifdef TSEQ_MAX_GREEN_EN
  // Green counts down from MAX_GREEN-1, so green cycle g = MAX_GREEN - cnt until it saturates at 0.
  localparam logic [CNT_W-1:0] GREEN_LOAD   = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] MIN_DONE_CNT = CNT_W'(MAX_GREEN - MIN_GREEN);
`else
  localparam logic [CNT_W-1:0] GREEN_LOAD   = CNT_W'(MIN_GREEN - 1);
`endif

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [PH_W-1:0]         phase_n, sel_phase, cand;
  logic [NUM_PHASES-1:0]   demand_q, demand_q_n;
  logic [NUM_PHASES-1:0]   own_mask, sel_mask, block_mask;
  logic [2*NUM_PHASES-1:0] light_n;
  logic                    sel_found, other, min_done, extend, enter_green;

  assign own_mask   = NUM_PHASES'(1) << phase_id;
  assign sel_mask   = NUM_PHASES'(1) << sel_phase;
  assign block_mask = (state == S_GREEN || state == S_YELLOW) ? own_mask : '0;
  assign other      = |(demand_q & ~own_mask);

`ifdef TSEQ_MAX_GREEN_EN
  assign min_done = (cnt <= MIN_DONE_CNT);
  assign extend   = demand[phase_id] && (cnt != '0);
`else
  assign min_done = (cnt == '0);
  assign extend   = 1'b0;
`endif

  // Round-robin search starting just after the current phase; the current phase is checked last.
  always_comb begin
    sel_found = 1'b0;
    sel_phase = phase_id;
    cand      = '0;
    for (int k = 1; k <= NUM_PHASES; k++) begin
      cand = PH_W'((int'(phase_id) + k) % NUM_PHASES);
      if (!sel_found && demand_q[cand]) begin
        sel_found = 1'b1;
        sel_phase = cand;
      end
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    phase_n     = phase_id;
    enter_green = 1'b0;
    if (flash) begin
      state_n = S_FLASH;
    end else begin
      unique case (state)
        S_ALL_RED: begin
          if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
          end else if (sel_found) begin
            state_n     = S_GREEN;
            cnt_n       = GREEN_LOAD;
            phase_n     = sel_phase;
            enter_green = 1'b1;
          end
        end
        S_GREEN: begin
          if (min_done && other && !extend) begin
            state_n = S_YELLOW;
            cnt_n   = YELLOW_LOAD;
          end else if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
          end
        end
        S_YELLOW: begin
          if (cnt == '0) begin
            state_n = S_ALL_RED;
            cnt_n   = ALL_RED_LOAD;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        S_FLASH: begin
          state_n = S_ALL_RED;
          cnt_n   = ALL_RED_LOAD;
        end
      endcase
    end
  end

  always_comb begin
    demand_q_n = demand_q | (demand & ~block_mask);
    if (enter_green) demand_q_n = demand_q_n & ~sel_mask;
  end

  // Lamps are decoded from the next state so the registered outputs line up with the state.
  always_comb begin
    light_n = {NUM_PHASES{2'b10}};
    if (state_n == S_FLASH) begin
      light_n = {NUM_PHASES{2'b11}};
    end else if (state_n == S_GREEN) begin
      light_n[{phase_n, 1'b0} +: 2] = 2'b00;
    end else if (state_n == S_YELLOW) begin
      light_n[{phase_n, 1'b0} +: 2] = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_ALL_RED;
      cnt         <= ALL_RED_LOAD;
      phase_id    <= PH_W'(NUM_PHASES - 1);
      demand_q    <= '0;
      light       <= {NUM_PHASES{2'b10}};
      green_start <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      phase_id    <= phase_n;
      demand_q    <= demand_q_n;
      light       <= light_n;
      green_start <= enter_green;
    end
  end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Testbench for traffic_phase_sequencer: directed scenarios plus random demand/flash traffic,
// compared every cycle against a cycle-count reference model of the signalling rules.
module tb_traffic_phase_sequencer;

  localparam int NP    = 4;
  localparam int MIN_G = 5;
  localparam int MAX_G = 20;
  localparam int YEL   = 3;
  localparam int AR    = 1;
`ifdef TSEQ_MAX_GREEN_EN
  localparam bit EXT    = 1'b1;
  localparam int T3_EXP = MAX_G;
`else
  localparam bit EXT    = 1'b0;
  localparam int T3_EXP = MIN_G;
`endif

  localparam int M_RED = 0;
  localparam int M_GRN = 1;
  localparam int M_YEL = 2;
  localparam int M_FLS = 3;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NP-1:0]   demand;
  logic            flash;
  logic [2*NP-1:0] light;
  logic [1:0]      phase_id;
  logic            green_start;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: mode, cycles left in the timed interval, green cycle count, pending requests.
  int m_mode, m_left, m_g, m_pid;
  bit m_pend[NP];
  bit m_gs;

  traffic_phase_sequencer #(
    .NUM_PHASES(NP), .CNT_W(8), .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G),
    .YELLOW_TIME(YEL), .ALL_RED_TIME(AR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .demand(demand), .flash(flash),
    .light(light), .phase_id(phase_id), .green_start(green_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_mode = M_RED;
    m_left = AR;
    m_g    = 0;
    m_pid  = NP - 1;
    m_gs   = 1'b0;
    for (int i = 0; i < NP; i++) m_pend[i] = 1'b0;
  endtask

  task automatic model_step(input logic [NP-1:0] d, input bit f);
    bit np[NP];
    bit oth;
    int pick;
    oth  = 1'b0;
    pick = -1;
    for (int i = 0; i < NP; i++) begin
      np[i] = m_pend[i] | (d[i] && !((m_mode == M_GRN || m_mode == M_YEL) && i == m_pid));
      if (i != m_pid && m_pend[i]) oth = 1'b1;
    end
    m_gs = 1'b0;
    if (f) begin
      m_mode = M_FLS;
    end else begin
      case (m_mode)
        M_RED: begin
          if (m_left > 1) m_left--;
          else begin
            for (int k = 1; k <= NP; k++)
              if (pick < 0 && m_pend[(m_pid + k) % NP]) pick = (m_pid + k) % NP;
            if (pick >= 0) begin
              m_mode   = M_GRN;
              m_pid    = pick;
              m_g      = 1;
              np[pick] = 1'b0;
              m_gs     = 1'b1;
            end
          end
        end
        M_GRN: begin
          if (m_g >= MIN_G && oth && !(EXT && d[m_pid] && m_g < MAX_G)) begin
            m_mode = M_YEL;
            m_left = YEL;
          end else if (m_g < 1000) m_g++;
        end
        M_YEL: begin
          if (m_left > 1) m_left--;
          else begin
            m_mode = M_RED;
            m_left = AR;
          end
        end
        default: begin
          m_mode = M_RED;
          m_left = AR;
        end
      endcase
    end
    m_pend = np;
  endtask

  function automatic logic [2*NP-1:0] model_light();
    logic [2*NP-1:0] l;
    for (int i = 0; i < NP; i++) begin
      if (m_mode == M_FLS)                      l[2*i +: 2] = 2'b11;
      else if (i == m_pid && m_mode == M_GRN)   l[2*i +: 2] = 2'b00;
      else if (i == m_pid && m_mode == M_YEL)   l[2*i +: 2] = 2'b01;
      else                                      l[2*i +: 2] = 2'b10;
    end
    return l;
  endfunction

  task automatic cycle(input logic [NP-1:0] d, input bit f);
    @(negedge clk);
    demand = d;
    flash  = f;
    model_step(d, f);
    @(posedge clk);
    #1;
    check("light", light, model_light());
    check("phase_id", phase_id, m_pid);
    check("green_start", green_start, m_gs);
  endtask

  task automatic wait_green(input logic [NP-1:0] d, input int ph);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      cycle((i == 0) ? d : '0, 1'b0);
      if (green_start && phase_id == ph) seen = 1'b1;
    end
    check("wait_green", seen, 1);
  endtask

  // Counts green/yellow/red cycles of lamp ph until the next green_start.
  task automatic measure(input logic [NP-1:0] d, input int ph, input int start_g,
                         input int exp_g, input int exp_y, input int exp_r, input int next_ph);
    int gc, yc, rc;
    bit done;
    gc = start_g; yc = 0; rc = 0; done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      cycle(d, 1'b0);
      if (green_start) done = 1'b1;
      else if (light[2*ph +: 2] == 2'b00) gc++;
      else if (light[2*ph +: 2] == 2'b01) yc++;
      else rc++;
    end
    check("measure_done", done, 1);
    check("measure_green", gc, exp_g);
    check("measure_yellow", yc, exp_y);
    check("measure_allred", rc, exp_r);
    check("measure_next", phase_id, next_ph);
  endtask

  initial begin
    int bad;
    logic [NP-1:0] hold;
    bit fl;
    reset_n = 1'b0;
    demand  = '0;
    flash   = 1'b0;
    model_reset();
    #12;
    check("reset_light", light, 8'hAA);
    check("reset_phase", phase_id, 3);
    check("reset_gs", green_start, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // single pulse after reset
    cycle(4'b0100, 1'b0);
    check("t1_red", light, 8'hAA);
    cycle(4'b0000, 1'b0);
    check("t1_green", light, 8'h8A);
    check("t1_gs", green_start, 1);
    check("t1_phase", phase_id, 2);
    cycle(4'b0000, 1'b0);
    check("t1_gs_once", green_start, 0);

    // minimum-green termination
    wait_green(4'b0001, 0);
    cycle(4'b0010, 1'b0);
    measure(4'b0000, 0, 2, MIN_G, YEL, AR, 1);

    // extension vs max-out, phases 1 and 2 skipped
    wait_green(4'b0001, 0);
    measure(4'b1001, 0, 1, T3_EXP, YEL, AR, 3);

    // rest in green
    wait_green(4'b0001, 0);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(4'b0001, 1'b0);
      if (light !== 8'hA8) bad++;
    end
    check("t4_rest_green", bad, 0);

    // flash mid-yellow
    cycle(4'b0100, 1'b0);
    cycle(4'b0000, 1'b0);
    check("t5_yellow", light, 8'hA9);
    cycle(4'b0000, 1'b1);
    check("t5_flash", light, 8'hFF);
    cycle(4'b0000, 1'b1);
    check("t5_flash_hold", light, 8'hFF);
    cycle(4'b0000, 1'b0);
    check("t5_allred", light, 8'hAA);
    cycle(4'b0000, 1'b0);
    check("t5_next_green", light, 8'h8A);
    check("t5_gs", green_start, 1);

    // reset mid-green discards pending demand
    cycle(4'b0010, 1'b0);
    reset_n = 1'b0;
    #1;
    check("t6_async_light", light, 8'hAA);
    check("t6_async_phase", phase_id, 3);
    check("t6_async_gs", green_start, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(4'b0000, 1'b0);
      if (light !== 8'hAA) bad++;
    end
    check("t6_rest_red", bad, 0);

    // random traffic against the model
    hold = '0;
    fl   = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) hold = 4'($urandom) & 4'($urandom);
      if (fl) fl = ($urandom_range(0, 2) != 0);
      else    fl = ($urandom_range(0, 59) == 0);
      cycle((4'($urandom) & 4'($urandom) & 4'($urandom)) | hold, fl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
